ecrc_seq_ctrl: RTL and testbench

Sequencer that drives the CRC32 ECRC engine in the TX data-fragmentation path. It accepts a TLP one 256-bit beat at a time from the fragmentation stage and feeds each beat to the combinational CRC32 engine. It keeps the running CRC between beats, re-folding the seed for each new beat, and at end-of-TLP it presents the final 32-bit ECRC to the append stage through a valid/ready handshake.

---
 rtl/ecrc_seq_ctrl.sv | 111 +++++++++++
 tb/tb_ecrc_seq_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecrc_seq_ctrl.sv
// Beat sequencer for the combinational CRC32 ECRC engine: carries the running CRC
// across the beats of a TLP and hands the final ECRC to the append stage.
module ecrc_seq_ctrl #(
  parameter int          DATA_WIDTH   = 256,
  parameter int          LENGTH_WIDTH = 4,
  parameter int          POLY_WIDTH   = 32,
  parameter int          BEAT_DW      = 8,
  parameter logic [31:0] CRC_INIT     = 32'hFFFF_FFFF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_sop,
  input  logic                    in_eop,
  input  logic [LENGTH_WIDTH-1:0] in_len,
  input  logic                    in_ecrc_req,
  output logic [DATA_WIDTH-1:0]   crc_message,
  output logic [LENGTH_WIDTH-1:0] crc_length,
  output logic                    crc_en,
  output logic [POLY_WIDTH-1:0]   crc_seed,
  output logic                    crc_seed_load,
  input  logic [POLY_WIDTH-1:0]   crc_result,
  input  logic                    crc_done,
  output logic                    ecrc_valid,
  input  logic                    ecrc_ready,
  output logic [POLY_WIDTH-1:0]   ecrc_out,
  output logic                    err_pulse
);

  // state  | meaning
  // IDLE   | waiting for an SOP beat
  // ACCUM  | inside a multi-beat TLP, running CRC held in r_crc
  // APPEND | final ECRC offered to the append stage, input stalled
  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_APPEND} state_t;

  localparam logic [LENGTH_WIDTH-1:0] LenFull = LENGTH_WIDTH'(BEAT_DW);

  state_t                  r_state, w_next;
  logic [POLY_WIDTH-1:0]   r_crc;
  logic                    r_td;
  logic                    r_err;
  logic                    w_accept, w_td_eff, w_drop, w_active, w_len_bad, w_err;

  // Undo the engine's per-byte bit reversal and output inversion.
  function automatic logic [POLY_WIDTH-1:0] fold(input logic [POLY_WIDTH-1:0] x);
    logic [POLY_WIDTH-1:0] s;
    s = '0;
    for (int k = 0; k < POLY_WIDTH/8; k++)
      for (int j = 0; j < 8; j++)
        s[8*k+j] = ~x[8*k+7-j];
    return s;
  endfunction

  assign w_accept  = in_valid & in_ready;
  assign w_td_eff  = in_sop ? in_ecrc_req : r_td;
  assign w_drop    = (r_state == S_IDLE) & ~in_sop;
  assign w_active  = w_accept & ~w_drop & w_td_eff;
  assign w_len_bad = (in_len == '0) | (in_len > LenFull);
  assign w_err     = w_accept & (w_drop | ((r_state == S_ACCUM) & in_sop) | (in_eop & w_len_bad));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_crc   <= '0;
      r_td    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= w_err;
      if (w_accept & in_sop) r_td  <= in_ecrc_req;
      if (w_active)          r_crc <= crc_result;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept & in_sop) begin
          if (in_eop) w_next = in_ecrc_req ? S_APPEND : S_IDLE;
          else        w_next = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (w_accept & in_eop) w_next = w_td_eff ? S_APPEND : S_IDLE;
      end
      S_APPEND: begin
        if (ecrc_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready      = (r_state != S_APPEND);
    ecrc_valid    = (r_state == S_APPEND);
    ecrc_out      = r_crc;
    err_pulse     = r_err;
    crc_en        = w_active;
    crc_message   = in_data;
    crc_seed_load = 1'b1;
    crc_length    = (in_eop & ~w_len_bad) ? in_len : LenFull;
    crc_seed      = in_sop ? CRC_INIT : fold(r_crc);
  end

  // The engine is combinational, so its Done must already be high whenever it is enabled.
  a_engine_done: assert property (@(posedge clk) disable iff (!rst) crc_en |-> crc_done);

endmodule

// File: tb/tb_ecrc_seq_ctrl.sv
// Directed bench for ecrc_seq_ctrl: a combinational CRC32 engine model plus a
// TLP-level reference that computes each ECRC over the whole byte stream at once.
module tb_ecrc_seq_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0, in_ready;
  logic [255:0] in_data = '0;
  logic         in_sop = 1'b0, in_eop = 1'b0;
  logic [3:0]   in_len = 4'd0;
  logic         in_ecrc_req = 1'b0;
  logic [255:0] crc_message;
  logic [3:0]   crc_length;
  logic         crc_en, crc_seed_load;
  logic [31:0]  crc_seed, crc_result;
  logic         crc_done;
  logic         ecrc_valid, ecrc_ready = 1'b0;
  logic [31:0]  ecrc_out;
  logic         err_pulse;

  int n_tests = 0;
  int n_fail  = 0;

  ecrc_seq_ctrl dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sop(in_sop), .in_eop(in_eop), .in_len(in_len), .in_ecrc_req(in_ecrc_req),
    .crc_message(crc_message), .crc_length(crc_length), .crc_en(crc_en),
    .crc_seed(crc_seed), .crc_seed_load(crc_seed_load),
    .crc_result(crc_result), .crc_done(crc_done),
    .ecrc_valid(ecrc_valid), .ecrc_ready(ecrc_ready), .ecrc_out(ecrc_out),
    .err_pulse(err_pulse)
  );

  always #5 clk = ~clk;

  // ---------------- CRC arithmetic ----------------
  function automatic logic [31:0] crc_byte(input logic [31:0] r, input logic [7:0] b);
    logic [31:0] x;
    x = r ^ {24'h0, b};
    for (int i = 0; i < 8; i++) x = x[0] ? ((x >> 1) ^ 32'hEDB8_8320) : (x >> 1);
    return x;
  endfunction

  function automatic logic [31:0] brev_bytes(input logic [31:0] x);
    logic [31:0] y;
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 8; j++) y[8*k+j] = x[8*k+7-j];
    return y;
  endfunction

  // Internal CRC register after a byte stream, starting from all ones.
  function automatic logic [31:0] raw_crc(input logic [7:0] q[$]);
    logic [31:0] r;
    r = 32'hFFFF_FFFF;
    foreach (q[i]) r = crc_byte(r, q[i]);
    return r;
  endfunction

  // ECRC as the engine presents it: inverted and bit-reversed within each byte.
  function automatic logic [31:0] ecrc_of(input logic [7:0] q[$]);
    return brev_bytes(~raw_crc(q));
  endfunction

  // Engine model: seed is the raw register, result is inverted + per-byte reversed.
  logic [31:0] eng_r;
  always_comb begin
    eng_r = crc_seed;
    for (int i = 0; i < 32; i++)
      if (i < int'(crc_length) * 4) eng_r = crc_byte(eng_r, crc_message[8*i +: 8]);
    crc_result = brev_bytes(~eng_r);
    crc_done   = 1'b1;
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- TLP-level reference ----------------
  logic [7:0]  m_bytes[$];
  logic        m_in_tlp, m_td, m_pending, m_err;
  logic [31:0] m_ecrc;

  function automatic logic [3:0] exp_len();
    if (!in_eop) return 4'd8;
    return (in_len >= 4'd1 && in_len <= 4'd8) ? in_len : 4'd8;
  endfunction

  always @(posedge clk or negedge rst) begin
    logic acc, drop, td, active;
    if (!rst) begin
      m_bytes.delete();
      m_in_tlp = 0; m_td = 0; m_pending = 0; m_err = 0; m_ecrc = '0;
    end else begin
      acc    = in_valid & ~m_pending;
      drop   = acc & ~m_in_tlp & ~in_sop;
      td     = in_sop ? in_ecrc_req : m_td;
      active = acc & ~drop & td;
      m_err  = acc & (drop | (in_sop & m_in_tlp) | (in_eop & (in_len == 0 || in_len > 8)));
      if (m_pending & ecrc_ready) m_pending = 0;
      if (acc & ~drop) begin
        if (in_sop) begin
          m_bytes.delete();
          m_td = in_ecrc_req;
        end
        if (active)
          for (int i = 0; i < 4 * int'(exp_len()); i++) m_bytes.push_back(in_data[8*i +: 8]);
        if (in_eop) begin
          m_in_tlp = 0;
          if (td) begin
            m_pending = 1;
            m_ecrc    = ecrc_of(m_bytes);
          end
        end else begin
          m_in_tlp = 1;
        end
      end
    end
  end

  // Per-cycle comparison against the reference, away from the active edge.
  always @(negedge clk) begin
    logic acc, drop, td, exp_en;
    if (rst) begin
      acc    = in_valid & ~m_pending;
      drop   = acc & ~m_in_tlp & ~in_sop;
      td     = in_sop ? in_ecrc_req : m_td;
      exp_en = acc & ~drop & td;
      chk("in_ready",   {255'd0, in_ready},   {255'd0, ~m_pending});
      chk("ecrc_valid", {255'd0, ecrc_valid}, {255'd0, m_pending});
      chk("err_pulse",  {255'd0, err_pulse},  {255'd0, m_err});
      chk("crc_en",     {255'd0, crc_en},     {255'd0, exp_en});
      chk("seed_load",  {255'd0, crc_seed_load}, 256'd1);
      if (m_pending) chk("ecrc_out", {224'd0, ecrc_out}, {224'd0, m_ecrc});
      if (exp_en) begin
        chk("crc_seed",    {224'd0, crc_seed},
            {224'd0, in_sop ? 32'hFFFF_FFFF : raw_crc(m_bytes)});
        chk("crc_length",  {252'd0, crc_length}, {252'd0, exp_len()});
        chk("crc_message", crc_message, in_data);
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [255:0] pat(input int s);
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[32*i +: 32] = (32'h9E37_79B9 * (s + 1)) ^ (32'h0101_0101 * i) ^ 32'(s << 20);
    return d;
  endfunction

  task automatic beat(input bit sop, input bit eop, input logic [3:0] len, input bit td,
                      input logic [255:0] d);
    in_valid = 1; in_sop = sop; in_eop = eop; in_len = len; in_ecrc_req = td; in_data = d;
    @(posedge clk); #1;
    in_valid = 0; in_sop = 0; in_eop = 0; in_len = 0; in_ecrc_req = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic handshake();
    ecrc_ready = 1;
    @(posedge clk); #1;
    ecrc_ready = 0;
    chk("post_hs_valid", {255'd0, ecrc_valid}, 256'd0);
    chk("post_hs_ready", {255'd0, in_ready},   256'd1);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [31:0] held;

    // Pin the reference against the standard CRC32 check value.
    q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    chk("pin_crc32_check", {224'd0, ~raw_crc(q)}, {224'd0, 32'hCBF4_3926});
    q.delete();
    chk("pin_crc32_empty", {224'd0, ~raw_crc(q)}, 256'd0);

    #12;
    chk("rst_valid",  {255'd0, ecrc_valid}, 256'd0);
    chk("rst_en",     {255'd0, crc_en},     256'd0);
    chk("rst_err",    {255'd0, err_pulse},  256'd0);
    chk("rst_ecrc",   {224'd0, ecrc_out},   256'd0);
    chk("rst_ready",  {255'd0, in_ready},   256'd1);
    rst = 1;
    idle(2);

    // Single beat TD=1 with one DW.
    in_valid = 1; in_sop = 1; in_eop = 1; in_len = 1; in_ecrc_req = 1; in_data = 256'h1;
    #2;
    chk("t1_en",   {255'd0, crc_en},     256'd1);
    chk("t1_seed", {224'd0, crc_seed},   {224'd0, 32'hFFFF_FFFF});
    chk("t1_len",  {252'd0, crc_length}, 256'd1);
    @(posedge clk); #1;
    in_valid = 0; in_sop = 0; in_eop = 0; in_len = 0; in_ecrc_req = 0;
    chk("t1_valid", {255'd0, ecrc_valid}, 256'd1);
    chk("t1_ready", {255'd0, in_ready},   256'd0);
    idle(1);
    chk("t1_ready_hold", {255'd0, in_ready}, 256'd0);
    handshake();

    // Three beats TD=1, EOP with 4 DWs.
    beat(1, 0, 4'd0, 1, pat(1));
    beat(0, 0, 4'd0, 0, pat(2));
    beat(0, 1, 4'd4, 0, pat(3));
    chk("t2_valid", {255'd0, ecrc_valid}, 256'd1);
    handshake();

    // TD=0 two beats followed immediately by a new SOP.
    beat(1, 0, 4'd0, 0, pat(4));
    beat(0, 1, 4'd8, 0, pat(5));
    chk("t3_ready_after_eop", {255'd0, in_ready}, 256'd1);
    beat(1, 1, 4'd8, 1, pat(6));
    chk("t3_valid", {255'd0, ecrc_valid}, 256'd1);

    // Back-pressure: five cycles with ecrc_ready low.
    held = ecrc_out;
    for (int i = 0; i < 5; i++) begin
      idle(1);
      chk("t4_stable", {224'd0, ecrc_out}, {224'd0, held});
      chk("t4_inready", {255'd0, in_ready}, 256'd0);
    end
    handshake();

    // Errors: beat without SOP in IDLE, SOP during ACCUM, EOP with len 0.
    beat(0, 1, 4'd2, 1, pat(7));
    chk("t5_err_drop", {255'd0, err_pulse}, 256'd1);
    chk("t5_no_append", {255'd0, ecrc_valid}, 256'd0);
    beat(1, 0, 4'd0, 1, pat(8));
    chk("t5_err_clear", {255'd0, err_pulse}, 256'd0);
    beat(1, 0, 4'd0, 1, pat(9));
    chk("t5_err_restart", {255'd0, err_pulse}, 256'd1);
    in_valid = 1; in_eop = 1; in_len = 0; in_data = pat(10);
    #2;
    chk("t5_clamp_len", {252'd0, crc_length}, 256'd8);
    @(posedge clk); #1;
    in_valid = 0; in_eop = 0;
    chk("t5_err_len0", {255'd0, err_pulse}, 256'd1);
    handshake();
    beat(1, 1, 4'd9, 1, pat(11));
    chk("t5_err_len9", {255'd0, err_pulse}, 256'd1);
    handshake();

    // Reset mid-ACCUM, then during APPEND.
    beat(1, 0, 4'd0, 1, pat(12));
    beat(0, 0, 4'd0, 0, pat(13));
    #2 rst = 0;
    #1;
    chk("t6_acc_valid", {255'd0, ecrc_valid}, 256'd0);
    chk("t6_acc_ready", {255'd0, in_ready},   256'd1);
    chk("t6_acc_crc",   {224'd0, ecrc_out},   256'd0);
    @(posedge clk); #3 rst = 1;
    idle(1);
    beat(1, 1, 4'd3, 1, pat(14));
    chk("t6_app_pre", {255'd0, ecrc_valid}, 256'd1);
    #2 rst = 0;
    #1;
    chk("t6_app_valid", {255'd0, ecrc_valid}, 256'd0);
    chk("t6_app_ready", {255'd0, in_ready},   256'd1);
    chk("t6_app_crc",   {224'd0, ecrc_out},   256'd0);
    @(posedge clk); #3 rst = 1;
    idle(1);
    beat(1, 0, 4'd0, 1, pat(15));
    beat(0, 1, 4'd6, 0, pat(16));
    chk("t6_after_valid", {255'd0, ecrc_valid}, 256'd1);
    handshake();
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
